// File: rtl/axi4_slave_mem_responder_if.sv
// AXI4 slave-side bus bundle for axi4_slave_mem_responder.
// Carries the AW, W and B write channels and the AR and R read channels.
// Signal names keep the s_ prefix seen on each slave-side port of the interconnect.
//   modport slave  : the memory responder (drives the ready, B and R signals).
//   modport master : the requester (drives the AW, W and AR payloads and B/R ready).
interface axi4_slave_mem_responder_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ID_WIDTH   = 8
) ();
   // Write address
   logic [ID_WIDTH-1:0]     s_awid;
   logic [ADDR_WIDTH-1:0]   s_awaddr;
   logic [7:0]              s_awlen;
   logic [2:0]              s_awsize;
   logic [1:0]              s_awburst;
   logic                    s_awvalid;
   logic                    s_awready;
   // Write data
   logic [DATA_WIDTH-1:0]   s_wdata;
   logic [DATA_WIDTH/8-1:0] s_wstrb;
   logic                    s_wlast;
   logic                    s_wvalid;
   logic                    s_wready;
   // Write response
   logic [ID_WIDTH-1:0]     s_bid;
   logic [1:0]              s_bresp;
   logic                    s_bvalid;
   logic                    s_bready;
   // Read address
   logic [ID_WIDTH-1:0]     s_arid;
   logic [ADDR_WIDTH-1:0]   s_araddr;
   logic [7:0]              s_arlen;
   logic [2:0]              s_arsize;
   logic [1:0]              s_arburst;
   logic                    s_arvalid;
   logic                    s_arready;
   // Read data
   logic [ID_WIDTH-1:0]     s_rid;
   logic [DATA_WIDTH-1:0]   s_rdata;
   logic [1:0]              s_rresp;
   logic                    s_rlast;
   logic                    s_rvalid;
   logic                    s_rready;

   modport slave (
      input  s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
      output s_awready,
      input  s_wdata, s_wstrb, s_wlast, s_wvalid,
      output s_wready,
      output s_bid, s_bresp, s_bvalid,
      input  s_bready,
      input  s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid,
      output s_arready,
      output s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
      input  s_rready
   );

   modport master (
      output s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
      input  s_awready,
      output s_wdata, s_wstrb, s_wlast, s_wvalid,
      input  s_wready,
      input  s_bid, s_bresp, s_bvalid,
      output s_bready,
      output s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid,
      input  s_arready,
      input  s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
      output s_rready
   );
endinterface

// File: rtl/axi4_slave_mem_responder.sv
// AXI4 slave endpoint backed by a word-addressed memory of MEM_DEPTH DATA_WIDTH-bit words.
// Every accepted write gets a B response and every accepted read returns len+1 R beats.
// Write and read paths are independent single-outstanding state machines.
//
// Ports:
//   aclk     : clock, rising edge.
//   aresetn  : asynchronous active-low reset (memory contents are not reset).
//   bus      : axi4_slave_mem_responder_if.slave (AW/W/B/AR/R channels).
//
// Optional feature macro: AXI_MEM_RESP_SLVERR_EN
//   defined   : word index >= MEM_DEPTH is out of range; such write beats are dropped and
//               flag SLVERR, such read beats return zero data with SLVERR.
//   undefined : word index is taken modulo MEM_DEPTH; responses are OKAY unless the
//               wlast check fails.
module axi4_slave_mem_responder #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ID_WIDTH   = 8,
   parameter int unsigned MEM_DEPTH  = 1024
) (
   input logic                       aclk,
   input logic                       aresetn,
   axi4_slave_mem_responder_if.slave bus
);

   localparam int unsigned StrbW     = DATA_WIDTH / 8;
   localparam int unsigned WordShift = $clog2(StrbW);
   localparam int unsigned IdxW      = $clog2(MEM_DEPTH);

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlvErr = 2'b10;
   localparam logic [1:0] BurstFixed = 2'b00;
   localparam logic [1:0] BurstWrap  = 2'b10;

   typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
   typedef enum logic       {RIdle, RData}        r_state_e;

   // Address of the beat following addr. WRAP with an illegal length degrades to INCR,
   // as does the reserved burst encoding 2'b11.
   function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [7:0]            len,
                                                        input logic [2:0]            size,
                                                        input logic [1:0]            burst);
      logic [ADDR_WIDTH-1:0] incr;
      logic [ADDR_WIDTH-1:0] mask;
      logic [ADDR_WIDTH-1:0] sum;
      logic                  wrap_ok;
      incr    = ADDR_WIDTH'(1) << size;
      mask    = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
      sum     = addr + incr;
      wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      if (burst == BurstFixed) begin
         next_addr = addr;
      end else if ((burst == BurstWrap) && wrap_ok) begin
         next_addr = (addr & ~mask) | (sum & mask);
      end else begin
         next_addr = sum;
      end
   endfunction

   // Truncation gives the modulo-MEM_DEPTH index.
   function automatic logic [IdxW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
      word_idx = IdxW'(addr >> WordShift);
   endfunction

`ifdef AXI_MEM_RESP_SLVERR_EN
   function automatic logic addr_oor(input logic [ADDR_WIDTH-1:0] addr);
      addr_oor = |(addr >> (WordShift + IdxW));
   endfunction
`endif

   logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

   // ------------------------------------------------------------------------------------------
   // Write path
   // ------------------------------------------------------------------------------------------
   w_state_e              w_state_q,  w_state_d;
   logic [ID_WIDTH-1:0]   aw_id_q,    aw_id_d;
   logic [ADDR_WIDTH-1:0] aw_addr_q,  aw_addr_d;
   logic [7:0]            aw_len_q,   aw_len_d;
   logic [2:0]            aw_size_q,  aw_size_d;
   logic [1:0]            aw_burst_q, aw_burst_d;
   logic [7:0]            w_cnt_q,    w_cnt_d;
   logic                  w_err_q,    w_err_d;
   logic                  aw_ready_q, aw_ready_d;
   logic                  aw_hs, w_hs, b_hs, w_last_beat, w_oor, w_en;
   logic [IdxW-1:0]       w_idx;

   assign aw_hs       = bus.s_awvalid & bus.s_awready;
   assign w_hs        = bus.s_wvalid & bus.s_wready;
   assign b_hs        = bus.s_bvalid & bus.s_bready;
   assign w_last_beat = (w_cnt_q == aw_len_q);
   assign w_idx       = word_idx(aw_addr_q);
`ifdef AXI_MEM_RESP_SLVERR_EN
   assign w_oor       = addr_oor(aw_addr_q);
`else
   assign w_oor       = 1'b0;
`endif
   assign w_en        = w_hs & ~w_oor;

   always_comb begin
      w_state_d  = w_state_q;
      aw_id_d    = aw_id_q;
      aw_addr_d  = aw_addr_q;
      aw_len_d   = aw_len_q;
      aw_size_d  = aw_size_q;
      aw_burst_d = aw_burst_q;
      w_cnt_d    = w_cnt_q;
      w_err_d    = w_err_q;
      unique case (w_state_q)
         WIdle: begin
            if (aw_hs) begin
               aw_id_d    = bus.s_awid;
               aw_addr_d  = bus.s_awaddr;
               aw_len_d   = bus.s_awlen;
               aw_size_d  = bus.s_awsize;
               aw_burst_d = bus.s_awburst;
               w_cnt_d    = 8'd0;
               w_err_d    = 1'b0;
               w_state_d  = WData;
            end
         end
         WData: begin
            if (w_hs) begin
               aw_addr_d = next_addr(aw_addr_q, aw_len_q, aw_size_q, aw_burst_q);
               w_cnt_d   = w_cnt_q + 8'd1;
               // The counter, not wlast, ends the burst; a disagreeing wlast only flags.
               if ((bus.s_wlast != w_last_beat) || w_oor) begin
                  w_err_d = 1'b1;
               end
               if (w_last_beat) begin
                  w_state_d = WResp;
               end
            end
         end
         WResp: begin
            if (b_hs) begin
               w_state_d = WIdle;
            end
         end
         default: w_state_d = WIdle;
      endcase
      // Registered so that awready is low while reset is held.
      aw_ready_d = (w_state_d == WIdle);
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         w_state_q  <= WIdle;
         aw_id_q    <= '0;
         aw_addr_q  <= '0;
         aw_len_q   <= '0;
         aw_size_q  <= '0;
         aw_burst_q <= '0;
         w_cnt_q    <= '0;
         w_err_q    <= 1'b0;
         aw_ready_q <= 1'b0;
      end else begin
         w_state_q  <= w_state_d;
         aw_id_q    <= aw_id_d;
         aw_addr_q  <= aw_addr_d;
         aw_len_q   <= aw_len_d;
         aw_size_q  <= aw_size_d;
         aw_burst_q <= aw_burst_d;
         w_cnt_q    <= w_cnt_d;
         w_err_q    <= w_err_d;
         aw_ready_q <= aw_ready_d;
      end
   end

   // Memory has no reset; contents persist across aresetn.
   always_ff @(posedge aclk) begin
      if (w_en) begin
         for (int unsigned b = 0; b < StrbW; b++) begin
            if (bus.s_wstrb[b]) begin
               mem_q[w_idx][b*8 +: 8] <= bus.s_wdata[b*8 +: 8];
            end
         end
      end
   end

   assign bus.s_awready = aw_ready_q;
   assign bus.s_wready  = (w_state_q == WData);
   assign bus.s_bvalid  = (w_state_q == WResp);
   assign bus.s_bid     = aw_id_q;
   assign bus.s_bresp   = w_err_q ? RespSlvErr : RespOkay;

   // ------------------------------------------------------------------------------------------
   // Read path
   // ------------------------------------------------------------------------------------------
   r_state_e              r_state_q,  r_state_d;
   logic [ID_WIDTH-1:0]   ar_id_q,    ar_id_d;
   logic [ADDR_WIDTH-1:0] r_addr_q,   r_addr_d;
   logic [7:0]            ar_len_q,   ar_len_d;
   logic [2:0]            ar_size_q,  ar_size_d;
   logic [1:0]            ar_burst_q, ar_burst_d;
   logic [7:0]            r_cnt_q,    r_cnt_d;
   logic                  r_last_q,   r_last_d;
   logic [DATA_WIDTH-1:0] r_data_q,   r_data_d;
   logic [1:0]            r_resp_q,   r_resp_d;
   logic                  ar_ready_q, ar_ready_d;
   logic                  ar_hs, r_hs, fetch;
   logic [ADDR_WIDTH-1:0] fetch_addr;

   assign ar_hs = bus.s_arvalid & bus.s_arready;
   assign r_hs  = bus.s_rvalid & bus.s_rready;

   always_comb begin
      r_state_d  = r_state_q;
      ar_id_d    = ar_id_q;
      r_addr_d   = r_addr_q;
      ar_len_d   = ar_len_q;
      ar_size_d  = ar_size_q;
      ar_burst_d = ar_burst_q;
      r_cnt_d    = r_cnt_q;
      r_last_d   = r_last_q;
      r_data_d   = r_data_q;
      r_resp_d   = r_resp_q;
      fetch      = 1'b0;
      fetch_addr = bus.s_araddr;
      unique case (r_state_q)
         RIdle: begin
            if (ar_hs) begin
               ar_id_d    = bus.s_arid;
               r_addr_d   = bus.s_araddr;
               ar_len_d   = bus.s_arlen;
               ar_size_d  = bus.s_arsize;
               ar_burst_d = bus.s_arburst;
               r_cnt_d    = 8'd0;
               r_last_d   = (bus.s_arlen == 8'd0);
               fetch      = 1'b1;
               r_state_d  = RData;
            end
         end
         RData: begin
            if (r_hs) begin
               if (r_last_q) begin
                  r_last_d  = 1'b0;
                  r_state_d = RIdle;
               end else begin
                  fetch_addr = next_addr(r_addr_q, ar_len_q, ar_size_q, ar_burst_q);
                  r_addr_d   = fetch_addr;
                  r_cnt_d    = r_cnt_q + 8'd1;
                  r_last_d   = ((r_cnt_q + 8'd1) == ar_len_q);
                  fetch      = 1'b1;
               end
            end
         end
         default: r_state_d = RIdle;
      endcase
      // mem_q is sampled at the same edge as any write, so a colliding read sees old data.
      if (fetch) begin
`ifdef AXI_MEM_RESP_SLVERR_EN
         if (addr_oor(fetch_addr)) begin
            r_data_d = '0;
            r_resp_d = RespSlvErr;
         end else begin
            r_data_d = mem_q[word_idx(fetch_addr)];
            r_resp_d = RespOkay;
         end
`else
         r_data_d = mem_q[word_idx(fetch_addr)];
         r_resp_d = RespOkay;
`endif
      end
      ar_ready_d = (r_state_d == RIdle);
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state_q  <= RIdle;
         ar_id_q    <= '0;
         r_addr_q   <= '0;
         ar_len_q   <= '0;
         ar_size_q  <= '0;
         ar_burst_q <= '0;
         r_cnt_q    <= '0;
         r_last_q   <= 1'b0;
         r_data_q   <= '0;
         r_resp_q   <= '0;
         ar_ready_q <= 1'b0;
      end else begin
         r_state_q  <= r_state_d;
         ar_id_q    <= ar_id_d;
         r_addr_q   <= r_addr_d;
         ar_len_q   <= ar_len_d;
         ar_size_q  <= ar_size_d;
         ar_burst_q <= ar_burst_d;
         r_cnt_q    <= r_cnt_d;
         r_last_q   <= r_last_d;
         r_data_q   <= r_data_d;
         r_resp_q   <= r_resp_d;
         ar_ready_q <= ar_ready_d;
      end
   end

   assign bus.s_arready = ar_ready_q;
   assign bus.s_rvalid  = (r_state_q == RData);
   assign bus.s_rid     = ar_id_q;
   assign bus.s_rdata   = r_data_q;
   assign bus.s_rresp   = r_resp_q;
   assign bus.s_rlast   = r_last_q;

endmodule

// File: tb/tb_axi4_slave_mem_responder.sv
// Directed self-checking bench for axi4_slave_mem_responder (64-bit data, 1024 words).
module tb_axi4_slave_mem_responder;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 64;
   localparam int unsigned IW = 8;
   localparam int unsigned MD = 1024;

   logic aclk;
   logic aresetn;
   int   checks;
   int   passes;

   logic [63:0] wd      [4];
   logic [63:0] rd      [4];
   logic [7:0]  rid_a   [4];
   logic [1:0]  rresp_a [4];
   logic        rlast_a [4];
   int          wait_n;

   axi4_slave_mem_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

   axi4_slave_mem_responder #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .ID_WIDTH  (IW),
      .MEM_DEPTH (MD)
   ) dut (
      .aclk   (aclk),
      .aresetn(aresetn),
      .bus    (bus)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic do_aw(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst, output bit ok);
      int n = 0;
      bus.s_awid = id; bus.s_awaddr = addr; bus.s_awlen = len;
      bus.s_awsize = size; bus.s_awburst = burst; bus.s_awvalid = 1'b1;
      while (bus.s_awready !== 1'b1 && n < 20) begin tick(); n++; end
      ok = (bus.s_awready === 1'b1);
      tick();
      bus.s_awvalid = 1'b0;
   endtask

   task automatic do_w(input logic [63:0] data, input logic [7:0] strb, input logic last,
                       output bit ok);
      int n = 0;
      bus.s_wdata = data; bus.s_wstrb = strb; bus.s_wlast = last; bus.s_wvalid = 1'b1;
      while (bus.s_wready !== 1'b1 && n < 20) begin tick(); n++; end
      ok = (bus.s_wready === 1'b1);
      tick();
      bus.s_wvalid = 1'b0;
   endtask

   task automatic do_b(output logic [7:0] id, output logic [1:0] resp, output bit ok);
      int n = 0;
      bus.s_bready = 1'b1;
      while (bus.s_bvalid !== 1'b1 && n < 20) begin tick(); n++; end
      wait_n = n;
      ok   = (bus.s_bvalid === 1'b1);
      id   = bus.s_bid;
      resp = bus.s_bresp;
      tick();
      bus.s_bready = 1'b0;
   endtask

   task automatic do_ar(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [2:0] size, input logic [1:0] burst, output bit ok);
      int n = 0;
      bus.s_arid = id; bus.s_araddr = addr; bus.s_arlen = len;
      bus.s_arsize = size; bus.s_arburst = burst; bus.s_arvalid = 1'b1;
      while (bus.s_arready !== 1'b1 && n < 20) begin tick(); n++; end
      ok = (bus.s_arready === 1'b1);
      tick();
      bus.s_arvalid = 1'b0;
   endtask

   task automatic do_r(output logic [63:0] data, output logic [7:0] id, output logic [1:0] resp,
                       output logic last, output bit ok);
      int n = 0;
      bus.s_rready = 1'b1;
      while (bus.s_rvalid !== 1'b1 && n < 20) begin tick(); n++; end
      wait_n = n;
      ok   = (bus.s_rvalid === 1'b1);
      data = bus.s_rdata;
      id   = bus.s_rid;
      resp = bus.s_rresp;
      last = bus.s_rlast;
      tick();
      bus.s_rready = 1'b0;
   endtask

   // Full-strobe size-3 write of wd[0..len]; wait_n afterwards holds the B wait in cycles.
   task automatic write_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, output logic [7:0] bid,
                              output logic [1:0] bresp, output bit ok);
      bit k;
      do_aw(id, addr, len, 3'd3, burst, k);
      ok = k;
      for (int i = 0; i <= int'(len); i++) begin
         do_w(wd[i], 8'hFF, (i == int'(len)), k);
         ok &= k;
      end
      do_b(bid, bresp, k);
      ok &= k;
   endtask

   task automatic read_burst(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, output int first_wait, output bit ok);
      bit k;
      first_wait = -1;
      do_ar(id, addr, len, 3'd3, burst, k);
      ok = k;
      for (int i = 0; i <= int'(len); i++) begin
         do_r(rd[i], rid_a[i], rresp_a[i], rlast_a[i], k);
         ok &= k;
         if (i == 0) first_wait = wait_n;
      end
   endtask

   task automatic test_reset();
      logic [23:0] ctl;
      aresetn = 1'b1;
      bus.s_awid = '0; bus.s_awaddr = '0; bus.s_awlen = '0; bus.s_awsize = '0;
      bus.s_awburst = '0; bus.s_awvalid = 1'b0;
      bus.s_wdata = '0; bus.s_wstrb = '0; bus.s_wlast = 1'b0; bus.s_wvalid = 1'b0;
      bus.s_bready = 1'b0;
      bus.s_arid = '0; bus.s_araddr = '0; bus.s_arlen = '0; bus.s_arsize = '0;
      bus.s_arburst = '0; bus.s_arvalid = 1'b0; bus.s_rready = 1'b0;
      #2 aresetn = 1'b0;
      repeat (3) tick();
      ctl = {bus.s_awready, bus.s_arready, bus.s_wready, bus.s_bvalid, bus.s_rvalid,
             bus.s_rlast, bus.s_bresp, bus.s_rresp, bus.s_bid, bus.s_rid};
      checks++;
      if (ctl !== 24'h0) $display("FAIL reset_ctl: got %h want %h", ctl, 24'h0);
      else passes++;
      checks++;
      if (bus.s_rdata !== 64'h0) $display("FAIL reset_rdata: got %h want 0", bus.s_rdata);
      else passes++;
      #2 aresetn = 1'b1;
      tick();
      checks++;
      if ({bus.s_awready, bus.s_arready, bus.s_wready} !== 3'b110)
         $display("FAIL reset_ready: got %b want 110",
                  {bus.s_awready, bus.s_arready, bus.s_wready});
      else passes++;
   endtask

   task automatic test_incr();
      bit ok;
      int fw;
      logic [7:0] bid;
      logic [1:0] bresp;
      logic [63:0] e;
      wd = '{64'h11, 64'h22, 64'h33, 64'h44};
      write_burst(8'h35, 32'h100, 8'd3, 2'b01, bid, bresp, ok);
      checks++;
      if (ok !== 1'b1) $display("FAIL incr_w_handshakes: got %b want 1", ok); else passes++;
      checks++;
      if (wait_n !== 0) $display("FAIL incr_b_latency: got %0d want 0", wait_n); else passes++;
      checks++;
      if ({bid, bresp} !== {8'h35, 2'b00})
         $display("FAIL incr_bresp: got id %h resp %b want id 35 resp 00", bid, bresp);
      else passes++;
      checks++;
      if (bus.s_awready !== 1'b1) $display("FAIL incr_awready_ret: got %b want 1", bus.s_awready);
      else passes++;
      read_burst(8'h12, 32'h100, 8'd3, 2'b01, fw, ok);
      checks++;
      if (ok !== 1'b1 || fw !== 0)
         $display("FAIL incr_r_latency: got ok %b wait %0d want ok 1 wait 0", ok, fw);
      else passes++;
      checks++;
      if (bus.s_arready !== 1'b1) $display("FAIL incr_arready_ret: got %b want 1", bus.s_arready);
      else passes++;
      for (int i = 0; i < 4; i++) begin
         e = 64'(17 * (i + 1));
         checks++;
         if ({rd[i], rid_a[i], rresp_a[i], rlast_a[i]} !== {e, 8'h12, 2'b00, (i == 3)})
            $display("FAIL incr_beat%0d: got data %h id %h resp %b last %b want data %h id 12",
                     i, rd[i], rid_a[i], rresp_a[i], rlast_a[i], e);
         else passes++;
      end
   endtask

   task automatic test_wrap();
      bit ok;
      int fw;
      logic [7:0] bid;
      logic [1:0] bresp;
      logic [63:0] exp_d [4];
      wd = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
      write_burst(8'h01, 32'h0, 8'd3, 2'b01, bid, bresp, ok);
      read_burst(8'h02, 32'h10, 8'd3, 2'b10, fw, ok);
      exp_d = '{64'hA2, 64'hA3, 64'hA0, 64'hA1};
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rd[i] !== exp_d[i] || rlast_a[i] !== (i == 3))
            $display("FAIL wrap_beat%0d: got %h last %b want %h", i, rd[i], rlast_a[i], exp_d[i]);
         else passes++;
      end
   endtask

   task automatic test_strobe();
      bit ok, k;
      int fw;
      logic [7:0] bid;
      logic [1:0] bresp;
      do_aw(8'h03, 32'h200, 8'd0, 3'd3, 2'b01, ok);
      do_w(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1, k); ok &= k;
      do_b(bid, bresp, k); ok &= k;
      do_aw(8'h04, 32'h200, 8'd0, 3'd3, 2'b01, k); ok &= k;
      do_w(64'h0, 8'h0F, 1'b1, k); ok &= k;
      do_b(bid, bresp, k); ok &= k;
      read_burst(8'h05, 32'h200, 8'd0, 2'b01, fw, k); ok &= k;
      checks++;
      if (ok !== 1'b1 || rd[0] !== 64'hFFFF_FFFF_0000_0000)
         $display("FAIL strobe_merge: got %h ok %b want ffffffff00000000", rd[0], ok);
      else passes++;
   endtask

   task automatic test_early_wlast();
      bit ok, k;
      int fw;
      int stuck;
      logic [7:0] bid;
      logic [1:0] bresp;
      // W offered with no AW must wait.
      stuck = 0;
      bus.s_wdata = 64'hBAD; bus.s_wstrb = 8'hFF; bus.s_wlast = 1'b1; bus.s_wvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (bus.s_wready !== 1'b0) stuck++;
         tick();
      end
      bus.s_wvalid = 1'b0;
      checks++;
      if (stuck !== 0) $display("FAIL w_before_aw: wready high %0d times want 0", stuck);
      else passes++;
      do_aw(8'h44, 32'h300, 8'd2, 3'd3, 2'b01, ok);
      do_w(64'h51, 8'hFF, 1'b1, k); ok &= k;
      do_w(64'h52, 8'hFF, 1'b0, k); ok &= k;
      do_w(64'h53, 8'hFF, 1'b0, k); ok &= k;
      checks++;
      if (ok !== 1'b1 || bus.s_wready !== 1'b0 || bus.s_bvalid !== 1'b1)
         $display("FAIL early_wlast_beats: ok %b wready %b bvalid %b want 1 0 1",
                  ok, bus.s_wready, bus.s_bvalid);
      else passes++;
      do_b(bid, bresp, k);
      checks++;
      if ({bid, bresp} !== {8'h44, 2'b10})
         $display("FAIL early_wlast_bresp: got id %h resp %b want id 44 resp 10", bid, bresp);
      else passes++;
      read_burst(8'h45, 32'h300, 8'd2, 2'b01, fw, k);
      checks++;
      if ({rd[0], rd[1], rd[2]} !== {64'h51, 64'h52, 64'h53})
         $display("FAIL early_wlast_data: got %h %h %h want 51 52 53", rd[0], rd[1], rd[2]);
      else passes++;
      wd[0] = 64'h54;
      write_burst(8'h46, 32'h318, 8'd0, 2'b01, bid, bresp, k);
      checks++;
      if (bresp !== 2'b00) $display("FAIL err_cleared: got resp %b want 00", bresp);
      else passes++;
   endtask

   task automatic test_backpressure();
      bit ok, k;
      logic [63:0] d;
      logic [7:0] id;
      logic [1:0] rs;
      logic l;
      logic [73:0] snap;
      do_ar(8'h12, 32'h100, 8'd3, 3'd3, 2'b01, ok);
      do_r(d, id, rs, l, k); ok &= k;
      for (int i = 0; i < 5; i++) begin
         tick();
         snap = {bus.s_rvalid, bus.s_rid, bus.s_rdata, bus.s_rlast};
         checks++;
         if (snap !== {1'b1, 8'h12, 64'h22, 1'b0})
            $display("FAIL bp_hold%0d: got valid %b id %h data %h last %b want 1 12 22 0",
                     i, bus.s_rvalid, bus.s_rid, bus.s_rdata, bus.s_rlast);
         else passes++;
      end
      do_r(d, id, rs, l, k); ok &= k;
      do_r(d, id, rs, l, k); ok &= k;
      checks++;
      if (d !== 64'h33 || l !== 1'b0) $display("FAIL bp_beat2: got %h last %b want 33 0", d, l);
      else passes++;
      do_r(d, id, rs, l, k); ok &= k;
      checks++;
      if (ok !== 1'b1 || d !== 64'h44 || l !== 1'b1)
         $display("FAIL bp_beat3: got %h last %b ok %b want 44 1 1", d, l, ok);
      else passes++;
   endtask

   task automatic test_collision();
      bit ok, k;
      int fw;
      logic [63:0] d;
      logic [7:0] id;
      logic [1:0] rs;
      logic l;
      do_aw(8'h66, 32'h100, 8'd0, 3'd3, 2'b01, ok);
      bus.s_wdata = 64'hDEAD; bus.s_wstrb = 8'hFF; bus.s_wlast = 1'b1; bus.s_wvalid = 1'b1;
      bus.s_arid = 8'h77; bus.s_araddr = 32'h100; bus.s_arlen = 8'd0;
      bus.s_arsize = 3'd3; bus.s_arburst = 2'b01; bus.s_arvalid = 1'b1;
      checks++;
      if ({bus.s_wready, bus.s_arready} !== 2'b11)
         $display("FAIL coll_ready: got %b want 11", {bus.s_wready, bus.s_arready});
      else passes++;
      tick();
      bus.s_wvalid = 1'b0;
      bus.s_arvalid = 1'b0;
      do_r(d, id, rs, l, k); ok &= k;
      checks++;
      if ({d, id, l} !== {64'h11, 8'h77, 1'b1})
         $display("FAIL coll_old_data: got %h id %h last %b want 11 77 1", d, id, l);
      else passes++;
      do_b(id, rs, k); ok &= k;
      read_burst(8'h78, 32'h100, 8'd0, 2'b01, fw, k); ok &= k;
      checks++;
      if (ok !== 1'b1 || rd[0] !== 64'hDEAD)
         $display("FAIL coll_new_data: got %h ok %b want dead 1", rd[0], ok);
      else passes++;
   endtask

   task automatic test_oor();
      bit ok, k;
      int fw;
      logic [7:0] bid;
      logic [1:0] bresp;
      logic [1:0] exp_b;
      logic [63:0] exp_hi, exp_w0;
      logic [1:0] exp_r;
`ifdef AXI_MEM_RESP_SLVERR_EN
      exp_b = 2'b10; exp_hi = 64'h0; exp_r = 2'b10; exp_w0 = 64'hA0;
`else
      exp_b = 2'b00; exp_hi = 64'h77; exp_r = 2'b00; exp_w0 = 64'h77;
`endif
      wd[0] = 64'h77;
      write_burst(8'h09, MD * 8, 8'd0, 2'b01, bid, bresp, ok);
      checks++;
      if (ok !== 1'b1 || bresp !== exp_b)
         $display("FAIL oor_bresp: got %b ok %b want %b", bresp, ok, exp_b);
      else passes++;
      read_burst(8'h0A, MD * 8, 8'd0, 2'b01, fw, k);
      checks++;
      if (rd[0] !== exp_hi || rresp_a[0] !== exp_r)
         $display("FAIL oor_read: got %h resp %b want %h resp %b", rd[0], rresp_a[0], exp_hi, exp_r);
      else passes++;
      read_burst(8'h0B, 32'h0, 8'd0, 2'b01, fw, k);
      checks++;
      if (rd[0] !== exp_w0 || rresp_a[0] !== 2'b00)
         $display("FAIL oor_word0: got %h resp %b want %h resp 00", rd[0], rresp_a[0], exp_w0);
      else passes++;
   endtask

   task automatic test_reset_mid_read();
      bit ok, k;
      int fw;
      logic [63:0] d;
      logic [7:0] id;
      logic [1:0] rs;
      logic l;
      do_ar(8'h21, 32'h100, 8'd3, 3'd3, 2'b01, ok);
      do_r(d, id, rs, l, k); ok &= k;
      checks++;
      if (ok !== 1'b1 || bus.s_rvalid !== 1'b1 || d !== 64'hDEAD)
         $display("FAIL rst_pre: got %h rvalid %b ok %b want dead 1 1", d, bus.s_rvalid, ok);
      else passes++;
      aresetn = 1'b0;
      #1;
      checks++;
      if ({bus.s_rvalid, bus.s_arready} !== 2'b00)
         $display("FAIL rst_in_reset: got rvalid/arready %b want 00", {bus.s_rvalid, bus.s_arready});
      else passes++;
      tick();
      tick();
      #3 aresetn = 1'b1;
      tick();
      checks++;
      if ({bus.s_arready, bus.s_rvalid} !== 2'b10)
         $display("FAIL rst_release: got arready/rvalid %b want 10", {bus.s_arready, bus.s_rvalid});
      else passes++;
      read_burst(8'h22, 32'h200, 8'd0, 2'b01, fw, k);
      checks++;
      if (k !== 1'b1 || rd[0] !== 64'hFFFF_FFFF_0000_0000)
         $display("FAIL rst_mem_kept: got %h ok %b want ffffffff00000000", rd[0], k);
      else passes++;
   endtask

   initial begin
      checks = 0;
      passes = 0;
      test_reset();
      test_incr();
      test_wrap();
      test_strobe();
      test_early_wlast();
      test_backpressure();
      test_collision();
      test_oor();
      test_reset_mid_read();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
